// File: rtl/i2s_stereo_rx.sv
// I2S / left-justified stereo ADC receiver. Captures codec frames into {channel,sample}
// words, buffers them in a first-word-fall-through FIFO and drives the codec MCLK.
module i2s_stereo_rx #(
    parameter int SAMPLE_W   = 16,
    parameter int MCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                listening,
    input  logic                lj_mode,
    input  logic [1:0]          ch_enable,
    input  logic                clr_status,
    input  logic                audio_sampl,
    input  logic                bclk,
    input  logic                audio_data,
    output logic                MCLK,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                sample_ch,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic [LVL_W-1:0]    level,
    output logic                overflow,
    output logic                frame_err
);

    localparam int HALF_DIV = MCLK_DIV / 2;
    localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int CNT_W    = $clog2(SAMPLE_W);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SKIP,
        SHIFT,
        PUSH,
        WAIT_EDGE
    } state_t;

    logic [2:0]          bclk_sync;
    logic [2:0]          lr_sync;
    logic [2:0]          data_sync;
    logic                bclk_rise;
    logic                lr_fall;
    logic                lr_rise;
    logic                lr_edge;
    logic                new_ch;
    logic                data_bit;

    logic [DIV_W-1:0]    mclk_cnt;

    state_t              state;
    state_t              start_state;
    logic [SAMPLE_W-1:0] shift_reg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                cur_ch;
    logic                cur_en;

    logic [SAMPLE_W:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    count;
    logic                full;
    logic                push_req;
    logic                wr_en;
    logic                pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            data_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], bclk};
            lr_sync   <= {lr_sync[1:0], audio_sampl};
            data_sync <= {data_sync[1:0], audio_data};
        end
    end

    // Index 2 is the oldest stage; edges compare it with the stage before it.
    assign bclk_rise   = bclk_sync[1] & ~bclk_sync[2];
    assign lr_fall     = ~lr_sync[1] & lr_sync[2];
    assign lr_rise     = lr_sync[1] & ~lr_sync[2];
    assign lr_edge     = lr_fall | lr_rise;
    assign new_ch      = lr_sync[1];
    assign data_bit    = data_sync[2];
    assign start_state = lj_mode ? SHIFT : SKIP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mclk_cnt <= '0;
            MCLK     <= 1'b0;
        end else if (mclk_cnt == DIV_W'(HALF_DIV - 1)) begin
            mclk_cnt <= '0;
            MCLK     <= ~MCLK;
        end else begin
            mclk_cnt <= mclk_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            cur_ch    <= 1'b0;
            cur_en    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (clr_status) begin
                frame_err <= 1'b0;
            end
            if (listening) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ALIGN;
                    end
                    // Only a left-frame start is accepted so L/R pairs stay ordered.
                    ALIGN: begin
                        if (lr_fall) begin
                            state   <= start_state;
                            cur_ch  <= 1'b0;
                            cur_en  <= ch_enable[0];
                            bit_cnt <= '0;
                        end
                    end
                    SKIP, SHIFT: begin
                        if (lr_edge) begin
                            frame_err <= 1'b1;
                            state     <= start_state;
                            cur_ch    <= new_ch;
                            cur_en    <= ch_enable[new_ch];
                            bit_cnt   <= '0;
                        end else if (bclk_rise) begin
                            if (state == SKIP) begin
                                state <= SHIFT;
                            end else begin
                                shift_reg <= {shift_reg[SAMPLE_W-2:0], data_bit};
                                if (bit_cnt == CNT_W'(SAMPLE_W - 1)) begin
                                    state <= PUSH;
                                end else begin
                                    bit_cnt <= bit_cnt + CNT_W'(1);
                                end
                            end
                        end
                    end
                    // A frame edge coinciding with the push still starts the next frame.
                    PUSH, WAIT_EDGE: begin
                        if (lr_edge) begin
                            state   <= start_state;
                            cur_ch  <= new_ch;
                            cur_en  <= ch_enable[new_ch];
                            bit_cnt <= '0;
                        end else begin
                            state <= WAIT_EDGE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign push_req = (state == PUSH) && cur_en;
    assign full     = (count == LVL_W'(FIFO_DEPTH));
    assign pop      = sample_valid && sample_ready;
    assign wr_en    = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {cur_ch, shift_reg};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count <= count + LVL_W'(1);
            end else if (!wr_en && pop) begin
                count <= count - LVL_W'(1);
            end
            if (clr_status) begin
                overflow <= 1'b0;
            end
            if (push_req && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    assign sample_valid             = (count != '0);
    assign {sample_ch, sample_data} = mem[rd_ptr];
    assign level                    = count;

endmodule
